cv32e40p_nmr_voter_monitor: RTL

Parametrised N-modular-redundancy voter with integrated per-channel breakage monitors, for the *_ft wrappers in the core. Votes N_CH replicas of a WIDTH-bit result and excludes channels declared broken. Tracks each channel's error history with saturating counters and reports detected, corrected and uncorrectable events. Generalises the fixed 3-way voter plus separate breakage monitors to N channels, an optional output register and event counting.

---
 rtl/cv32e40p_nmr_voter_monitor.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/cv32e40p_nmr_voter_monitor.sv
// N-way redundancy voter with per-channel saturating breakage monitors and event counters.
// Defining FT_RECOVERY_EN adds a probation path that lets a broken channel rejoin the vote.
module cv32e40p_nmr_voter_monitor #(
    parameter int N_CH           = 3,
    parameter int WIDTH          = 32,
    parameter int REG_OUT        = 0,
    parameter int INCREMENT      = 4,
    parameter int DECREMENT      = 1,
    parameter int COUNT_BIT      = 8,
    parameter int THRESHOLD      = 32,
    parameter int EVT_BIT        = 16,
    parameter int RECOVER_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic [N_CH*WIDTH-1:0]   to_vote_i,
    input  logic [N_CH-1:0]         set_broken_i,
    input  logic [N_CH-1:0]         clear_broken_i,
    output logic [WIDTH-1:0]        voted_o,
    output logic                    err_detected_o,
    output logic                    err_corrected_o,
    output logic                    err_uncorrectable_o,
    output logic                    all_broken_o,
    output logic [N_CH-1:0]         is_broken_o,
    output logic [EVT_BIT-1:0]      det_cnt_o,
    output logic [EVT_BIT-1:0]      unc_cnt_o
);
    // state        | meaning
    // ST_HEALTHY   | channel votes; error counter tracks disagreements
    // ST_BROKEN    | excluded from the vote; error counter frozen
    // ST_PROBATION | excluded; serving clean cycles before rejoining
    typedef enum logic [1:0] {
        ST_HEALTHY   = 2'd0,
        ST_BROKEN    = 2'd1,
        ST_PROBATION = 2'd2
    } state_e;

    localparam int CW      = $clog2(2*N_CH + 2);
    localparam int CNT_MAX = (1 << COUNT_BIT) - 1;

    state_e                 r_state [N_CH];
    logic [COUNT_BIT-1:0]   r_cnt [N_CH];
    logic [EVT_BIT-1:0]     r_det_cnt;
    logic [EVT_BIT-1:0]     r_unc_cnt;

    logic [WIDTH-1:0]       w_ch [N_CH];
    logic [N_CH-1:0]        w_healthy;
    logic [CW-1:0]          w_hcnt;
    logic [WIDTH-1:0]       w_low_word;
    logic [WIDTH-1:0]       w_voted;
    logic                   w_tie;
    logic [N_CH-1:0]        w_err;
    logic                   w_det;
    logic                   w_cor;
    logic                   w_unc;
    logic                   w_allb;
    logic [COUNT_BIT-1:0]   w_cnt_nxt [N_CH];
    logic [N_CH-1:0]        w_trip;

    // Walk downwards so the lowest-index healthy channel is the last one latched.
    always_comb begin
        w_hcnt     = '0;
        w_low_word = to_vote_i[WIDTH-1:0];
        for (int m = N_CH-1; m >= 0; m--) begin
            w_ch[m]      = to_vote_i[m*WIDTH +: WIDTH];
            w_healthy[m] = (r_state[m] == ST_HEALTHY);
            if (w_healthy[m]) begin
                w_hcnt     = w_hcnt + CW'(1);
                w_low_word = w_ch[m];
            end
        end
    end

    // With no healthy channel the tie branch yields channel 0 without raising a tie.
    always_comb begin
        logic [CW-1:0] w_ones;
        w_ones  = '0;
        w_voted = '0;
        w_tie   = 1'b0;
        for (int b = 0; b < WIDTH; b++) begin
            w_ones = '0;
            for (int m = 0; m < N_CH; m++) begin
                if (w_healthy[m] && w_ch[m][b]) w_ones = w_ones + CW'(1);
            end
            if ((w_ones << 1) > w_hcnt) begin
                w_voted[b] = 1'b1;
            end else if (((w_hcnt - w_ones) << 1) > w_hcnt) begin
                w_voted[b] = 1'b0;
            end else begin
                w_voted[b] = w_low_word[b];
                w_tie      = w_tie | (w_hcnt != '0);
            end
        end
    end

    always_comb begin
        for (int m = 0; m < N_CH; m++) begin
            w_err[m] = valid_i && w_healthy[m] && (w_ch[m] != w_voted);
        end
        w_det  = |w_err;
        w_unc  = valid_i && w_tie;
        w_cor  = w_det && !w_tie;
        w_allb = valid_i && (w_hcnt == '0);
    end

    always_comb begin
        int v_next;
        v_next = 0;
        for (int m = 0; m < N_CH; m++) begin
            v_next = int'(r_cnt[m]);
            if (w_err[m]) begin
                v_next = (v_next + INCREMENT > CNT_MAX) ? CNT_MAX : v_next + INCREMENT;
            end else if (valid_i) begin
                v_next = (v_next < DECREMENT) ? 0 : v_next - DECREMENT;
            end
            w_cnt_nxt[m] = COUNT_BIT'(v_next);
            w_trip[m]    = (v_next >= THRESHOLD);
        end
    end

`ifdef FT_RECOVERY_EN
    localparam int RW = $clog2(RECOVER_CYCLES + 1);
    logic [RW-1:0]   r_rec [N_CH];
    logic [N_CH-1:0] w_match;

    always_comb begin
        for (int m = 0; m < N_CH; m++) begin
            w_match[m] = (w_ch[m] == w_voted);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int m = 0; m < N_CH; m++) begin
                r_state[m] <= ST_HEALTHY;
                r_cnt[m]   <= '0;
`ifdef FT_RECOVERY_EN
                r_rec[m]   <= '0;
`endif
            end
            r_det_cnt <= '0;
            r_unc_cnt <= '0;
        end else begin
            for (int m = 0; m < N_CH; m++) begin
                if (set_broken_i[m]) begin
                    r_state[m] <= ST_BROKEN;
`ifdef FT_RECOVERY_EN
                    r_rec[m]   <= '0;
`endif
                end else if (clear_broken_i[m]) begin
                    r_state[m] <= ST_HEALTHY;
                    r_cnt[m]   <= '0;
`ifdef FT_RECOVERY_EN
                    r_rec[m]   <= '0;
`endif
                end else begin
                    case (r_state[m])
                        ST_HEALTHY: begin
                            r_cnt[m] <= w_cnt_nxt[m];
                            if (w_trip[m]) r_state[m] <= ST_BROKEN;
                        end
`ifdef FT_RECOVERY_EN
                        // Recovery run must be unbroken; an idle cycle restarts it.
                        ST_BROKEN: begin
                            if (valid_i && w_match[m]) begin
                                if (int'(r_rec[m]) + 1 >= RECOVER_CYCLES) begin
                                    r_state[m] <= ST_PROBATION;
                                    r_rec[m]   <= '0;
                                end else begin
                                    r_rec[m] <= r_rec[m] + RW'(1);
                                end
                            end else begin
                                r_rec[m] <= '0;
                            end
                        end
                        ST_PROBATION: begin
                            if (valid_i) begin
                                if (!w_match[m]) begin
                                    r_state[m] <= ST_BROKEN;
                                    r_rec[m]   <= '0;
                                end else if (int'(r_rec[m]) + 1 >= RECOVER_CYCLES) begin
                                    r_state[m] <= ST_HEALTHY;
                                    r_cnt[m]   <= COUNT_BIT'(THRESHOLD / 2);
                                    r_rec[m]   <= '0;
                                end else begin
                                    r_rec[m] <= r_rec[m] + RW'(1);
                                end
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
            if (w_det && (r_det_cnt != '1)) r_det_cnt <= r_det_cnt + EVT_BIT'(1);
            if (w_unc && (r_unc_cnt != '1)) r_unc_cnt <= r_unc_cnt + EVT_BIT'(1);
        end
    end

    assign is_broken_o = ~w_healthy;
    assign det_cnt_o   = r_det_cnt;
    assign unc_cnt_o   = r_unc_cnt;

    generate
        if (REG_OUT != 0) begin : g_reg_out
            logic [WIDTH-1:0] r_voted;
            logic             r_det;
            logic             r_cor;
            logic             r_unc;
            logic             r_allb;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_voted <= '0;
                    r_det   <= 1'b0;
                    r_cor   <= 1'b0;
                    r_unc   <= 1'b0;
                    r_allb  <= 1'b0;
                end else begin
                    r_voted <= w_voted;
                    r_det   <= w_det;
                    r_cor   <= w_cor;
                    r_unc   <= w_unc;
                    r_allb  <= w_allb;
                end
            end

            assign voted_o             = r_voted;
            assign err_detected_o      = r_det;
            assign err_corrected_o     = r_cor;
            assign err_uncorrectable_o = r_unc;
            assign all_broken_o        = r_allb;
        end else begin : g_comb_out
            assign voted_o             = w_voted;
            assign err_detected_o      = w_det;
            assign err_corrected_o     = w_cor;
            assign err_uncorrectable_o = w_unc;
            assign all_broken_o        = w_allb;
        end
    endgenerate

endmodule
